i8255_ppi: RTL and testbench
============================

Name: i8255_ppi

Overview:
- Synchronous FPGA re-implementation of the Intel 8255 programmable peripheral interface, Mode 0 (basic I/O) only.
- Exposes an 8-bit bidirectional host data bus with chip-select, read and write strobes.
- Provides three 8-bit bidirectional peripheral ports: A, B, and C, with C split into upper and lower nibbles.
- Supports a control register for port direction and a bit set/reset command for port C.

Parameters:
- None.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- cs  in  1  chip select, active-high.
- rd  in  1  read strobe, active-high.
- wr  in  1  write strobe, active-high.
- a  in  2  register select: 00=PA, 01=PB, 10=PC, 11=control.
- d  inout  8  host data bus; Hi-Z unless a read is in progress.
- pa  inout  8  port A pins.
- pb  inout  8  port B pins.
- pc  inout  8  port C pins; [7:4]=CH, [3:0]=CL.

Behaviour:
- Reset (reset=0 at a rising clk edge):
  - control register = 8'h9B (all ports inputs).
  - Output latches lat_a, lat_b, lat_c = 8'h00.
  - pa, pb, pc and d all Hi-Z.
- Write: on each rising clk edge with cs=1 and wr=1, a write is committed. Writes are level-sampled; repeating the same write across several edges is harmless.
  - a=00: lat_a <= d.
  - a=01: lat_b <= d.
  - a=10: lat_c <= d.
  - a=11 and d[7]=1 (mode set): control <= d; lat_a, lat_b, lat_c cleared to 00.
  - a=11 and d[7]=0 (bit set/reset): lat_c[d[3:1]] <= d[0]; all other lat_c bits and the control register are unchanged.
- Mode-set field decoding:
  - d[4]: 1 = A input, 0 = A output.
  - d[3]: 1 = CH input, 0 = CH output.
  - d[1]: 1 = B input, 0 = B output.
  - d[0]: 1 = CL input, 0 = CL output.
  - d[6:5] and d[2] (mode selects) are stored but ignored; the block always operates in Mode 0.
- Port drive (combinational from registered state):
  - Each port or nibble drives its latch when configured as output; otherwise Hi-Z.
  - New latch or direction values appear on the pins in the same cycle as the committing edge (registered outputs, no extra latency).
  - Writes to a port configured as input still update its latch; the value appears when the port is later switched to output, unless a mode set has cleared it.
- Read: while cs=1, rd=1 and wr=0, d is driven combinationally.
  - Port A/B: pin value if the port is an input, latch value if an output.
  - Port C: per nibble, same rule as A/B.
  - a=11: returns the control register.
  - In every other case d is Hi-Z.
- cs=1 with rd=1 and wr=1 together: the write is committed and d is not driven, avoiding bus contention.
- cs=0: rd and wr are ignored.
- reset has priority over any simultaneous write.

Decomposition:
- Package i8255_pkg holds:
  - address constants ADDR_PA/PB/PC/CTRL.
  - control-word bit positions: MODE_SET=7, A_IN=4, CH_IN=3, B_IN=1, CL_IN=0.
  - CTRL_RESET = 8'h9B.
- One sub-module, i8255_io_port, parameterized by WIDTH (8 for A and B, 4 for each C nibble):
  - contains the output latch and the tristate driver.
  - returns the read-back value.
- The top level holds the control register, address decode, bit set/reset logic and the host-bus tristate.

Test Plan:
- Reset held low 4 cycles, then released:
  - pa, pb, pc = ZZ.
  - Read of a=11 returns 9B.
- Write all 16 mode words 80, 81, 82, 83, 88, 89, 8A, 8B, 90, 91, 92, 93, 98, 99, 9A, 9B to a=11:
  - each port/nibble tristates exactly per bits 4, 3, 1, 0.
  - e.g. 81 → A, B, CH driven 0; CL Z. 9A → A, B, CH Z; CL driven 0.
- Write ctrl 80, then PA=A5, PB=5A, PC=96:
  - pins show A5, 5A, 96 after each committing edge.
  - Reads return the same values.
- With PC=96, write ctrl 0E (reset PC7):
  - pc = 16.
  - Then write 0F → pc = 96; then 01 → pc = 97.
- Ctrl 9B, drive pa=3C, pb=C3, pc=5A externally:
  - reads return 3C, C3, 5A.
  - Write PA=FF, then ctrl 80: pa = 00 (mode set clears the latch).
- Reset asserted mid-operation with outputs driven: next edge returns all ports to Z and control to 9B; a simultaneous cs/wr write is ignored.

Source files
------------

// File: rtl/i8255_pkg.sv
// Shared constants for the 8255-style PPI: register addresses, control-word
// bit positions and the bit set/reset helper for port C.
package i8255_pkg;

  localparam logic [1:0] ADDR_PA   = 2'b00;
  localparam logic [1:0] ADDR_PB   = 2'b01;
  localparam logic [1:0] ADDR_PC   = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  localparam int MODE_SET = 7;
  localparam int A_IN     = 4;
  localparam int CH_IN    = 3;
  localparam int B_IN     = 1;
  localparam int CL_IN    = 0;

  localparam logic [7:0] CTRL_RESET = 8'h9B;

  // Apply a bit set/reset command word to the current port C latch:
  // cmd[3:1] selects the bit and cmd[0] is the value written into it.
  function automatic logic [7:0] bsr_apply(input logic [7:0] cur, input logic [7:0] cmd);
    logic [7:0] r;
    r = cur;
    r[cmd[3:1]] = cmd[0];
    return r;
  endfunction

endpackage

// File: rtl/i8255_io_port.sv
// One peripheral port (or port C nibble): output latch, pin tristate driver
// and read-back selection (the latch when driving, the pins otherwise).
module i8255_io_port
  import i8255_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             drive,
  input  logic [WIDTH-1:0] load_data,
  inout  wire  [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] latch,
  output logic [WIDTH-1:0] rd_val
);

  // Output latch: a mode set clears it, a port write loads it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      latch <= '0;
    end else if (clear) begin
      latch <= '0;
    end else if (load) begin
      latch <= load_data;
    end
  end

  assign pins   = drive ? latch : {WIDTH{1'bz}};
  assign rd_val = drive ? latch : pins;

endmodule

// File: rtl/i8255_ppi.sv
// Mode 0 PPI top level: control register, host address decode, port C
// bit set/reset, and the host data bus tristate.
module i8255_ppi
  import i8255_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic [1:0] a,
  inout  wire  [7:0] d,
  inout  wire  [7:0] pa,
  inout  wire  [7:0] pb,
  inout  wire  [7:0] pc
);

  logic [7:0] ctrl;
  logic [7:0] lat_a, lat_b, lat_c;
  logic [7:0] rd_a, rd_b, rd_c;
  logic [7:0] c_data, rd_data;
  logic       wr_cmt, rd_en, wr_ctrl, mode_set, bsr, load_c;

  // A write wins over a simultaneous read so the host bus is never contended.
  assign wr_cmt   = cs & wr;
  assign rd_en    = cs & rd & ~wr;
  assign wr_ctrl  = wr_cmt & (a == ADDR_CTRL);
  assign mode_set = wr_ctrl & d[MODE_SET];
  assign bsr      = wr_ctrl & ~d[MODE_SET];
  assign load_c   = (wr_cmt & (a == ADDR_PC)) | bsr;
  assign c_data   = bsr ? bsr_apply(lat_c, d) : d;

  // Control register: only a mode-set word replaces it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl <= CTRL_RESET;
    end else if (mode_set) begin
      ctrl <= d;
    end
  end

  i8255_io_port #(.WIDTH(8)) u_port_a (
    .clk(clk), .reset(reset), .load(wr_cmt & (a == ADDR_PA)), .clear(mode_set),
    .drive(~ctrl[A_IN]), .load_data(d), .pins(pa), .latch(lat_a), .rd_val(rd_a)
  );

  i8255_io_port #(.WIDTH(8)) u_port_b (
    .clk(clk), .reset(reset), .load(wr_cmt & (a == ADDR_PB)), .clear(mode_set),
    .drive(~ctrl[B_IN]), .load_data(d), .pins(pb), .latch(lat_b), .rd_val(rd_b)
  );

  i8255_io_port #(.WIDTH(4)) u_port_ch (
    .clk(clk), .reset(reset), .load(load_c), .clear(mode_set),
    .drive(~ctrl[CH_IN]), .load_data(c_data[7:4]), .pins(pc[7:4]),
    .latch(lat_c[7:4]), .rd_val(rd_c[7:4])
  );

  i8255_io_port #(.WIDTH(4)) u_port_cl (
    .clk(clk), .reset(reset), .load(load_c), .clear(mode_set),
    .drive(~ctrl[CL_IN]), .load_data(c_data[3:0]), .pins(pc[3:0]),
    .latch(lat_c[3:0]), .rd_val(rd_c[3:0])
  );

  // Host read mux.
  always_comb begin
    rd_data = ctrl;
    case (a)
      ADDR_PA: rd_data = rd_a;
      ADDR_PB: rd_data = rd_b;
      ADDR_PC: rd_data = rd_c;
      default: rd_data = ctrl;
    endcase
  end

  assign d = rd_en ? rd_data : 8'bz;

endmodule

// File: tb/tb_i8255_ppi.sv
// Self-checking bench for i8255_ppi. All bus nets carry pull-ups, so a
// released (Hi-Z) pin or bus reads as 8'hFF and a driven one reads its value.
module tb_i8255_ppi;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [1:0] a = 2'b00;
  wire  [7:0] d, pa, pb, pc;

  logic [7:0] d_drv = 8'h00;
  logic       d_oe = 1'b0;
  logic [7:0] ext_pa = 8'h00, ext_pb = 8'h00, ext_pc = 8'h00;
  logic       pa_oe = 1'b0, pb_oe = 1'b0, pch_oe = 1'b0, pcl_oe = 1'b0;

  int errors = 0;
  int checks = 0;

  assign d       = d_oe   ? d_drv       : 8'bz;
  assign pa      = pa_oe  ? ext_pa      : 8'bz;
  assign pb      = pb_oe  ? ext_pb      : 8'bz;
  assign pc[7:4] = pch_oe ? ext_pc[7:4] : 4'bz;
  assign pc[3:0] = pcl_oe ? ext_pc[3:0] : 4'bz;

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (d[i]);
    pullup (pa[i]);
    pullup (pb[i]);
    pullup (pc[i]);
  end

  i8255_ppi dut (
    .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .a(a),
    .d(d), .pa(pa), .pb(pb), .pc(pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       wr_op;
    logic [1:0] ad;
    logic [7:0] dat;
    logic [7:0] e_pa, e_pb, e_pc, e_d;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  // Reference model state for the randomized phase.
  logic [7:0] m_ctrl;
  logic [7:0] m_lat[3];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] ad, input logic [7:0] dat);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; a = ad; d_drv = dat; d_oe = 1'b1;
    step();
    cs = 1'b0; wr = 1'b0; d_oe = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] ad, output logic [7:0] val);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; a = ad;
    #2;
    val = d;
    cs = 1'b0; rd = 1'b0;
    #1;
  endtask

  task automatic chk_pins(input string nm, input logic [7:0] ea, input logic [7:0] eb,
                          input logic [7:0] ec);
    chk({nm, " pa"}, pa, ea);
    chk({nm, " pb"}, pb, eb);
    chk({nm, " pc"}, pc, ec);
  endtask

  function automatic void add(input logic w, input logic [1:0] ad, input logic [7:0] dat,
                              input logic [7:0] ea, input logic [7:0] eb,
                              input logic [7:0] ec, input logic [7:0] ed, input string nm);
    vec_t v;
    v.wr_op = w; v.ad = ad; v.dat = dat;
    v.e_pa = ea; v.e_pb = eb; v.e_pc = ec; v.e_d = ed; v.nm = nm;
    vecs.push_back(v);
  endfunction

  // Pin value expected from the model: output latch where configured as
  // output, otherwise whatever the bench drives externally.
  function automatic logic [7:0] exp_pin(input int p);
    logic [7:0] r;
    case (p)
      0: r = m_ctrl[4] ? ext_pa : m_lat[0];
      1: r = m_ctrl[1] ? ext_pb : m_lat[1];
      default: begin
        r[7:4] = m_ctrl[3] ? ext_pc[7:4] : m_lat[2][7:4];
        r[3:0] = m_ctrl[0] ? ext_pc[3:0] : m_lat[2][3:0];
      end
    endcase
    return r;
  endfunction

  initial begin
    logic [7:0] rv, w, dat;
    int         op, ad;

    // Directed vectors: mode words, port writes, readback, bit set/reset.
    add(1, 2'b11, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, "mode80");
    add(1, 2'b11, 8'h81, 8'h00, 8'h00, 8'h0F, 8'h00, "mode81");
    add(1, 2'b11, 8'h82, 8'h00, 8'hFF, 8'h00, 8'h00, "mode82");
    add(1, 2'b11, 8'h83, 8'h00, 8'hFF, 8'h0F, 8'h00, "mode83");
    add(1, 2'b11, 8'h88, 8'h00, 8'h00, 8'hF0, 8'h00, "mode88");
    add(1, 2'b11, 8'h89, 8'h00, 8'h00, 8'hFF, 8'h00, "mode89");
    add(1, 2'b11, 8'h8A, 8'h00, 8'hFF, 8'hF0, 8'h00, "mode8A");
    add(1, 2'b11, 8'h8B, 8'h00, 8'hFF, 8'hFF, 8'h00, "mode8B");
    add(1, 2'b11, 8'h90, 8'hFF, 8'h00, 8'h00, 8'h00, "mode90");
    add(1, 2'b11, 8'h91, 8'hFF, 8'h00, 8'h0F, 8'h00, "mode91");
    add(1, 2'b11, 8'h92, 8'hFF, 8'hFF, 8'h00, 8'h00, "mode92");
    add(1, 2'b11, 8'h93, 8'hFF, 8'hFF, 8'h0F, 8'h00, "mode93");
    add(1, 2'b11, 8'h98, 8'hFF, 8'h00, 8'hF0, 8'h00, "mode98");
    add(1, 2'b11, 8'h99, 8'hFF, 8'h00, 8'hFF, 8'h00, "mode99");
    add(1, 2'b11, 8'h9A, 8'hFF, 8'hFF, 8'hF0, 8'h00, "mode9A");
    add(1, 2'b11, 8'h9B, 8'hFF, 8'hFF, 8'hFF, 8'h00, "mode9B");
    add(1, 2'b11, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, "ctrl80");
    add(1, 2'b00, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, "wr_pa");
    add(1, 2'b01, 8'h5A, 8'hA5, 8'h5A, 8'h00, 8'h00, "wr_pb");
    add(1, 2'b10, 8'h96, 8'hA5, 8'h5A, 8'h96, 8'h00, "wr_pc");
    add(0, 2'b00, 8'h00, 8'hA5, 8'h5A, 8'h96, 8'hA5, "rd_pa");
    add(0, 2'b01, 8'h00, 8'hA5, 8'h5A, 8'h96, 8'h5A, "rd_pb");
    add(0, 2'b10, 8'h00, 8'hA5, 8'h5A, 8'h96, 8'h96, "rd_pc");
    add(1, 2'b11, 8'h0E, 8'hA5, 8'h5A, 8'h16, 8'h00, "bsr0E");
    add(1, 2'b11, 8'h0F, 8'hA5, 8'h5A, 8'h96, 8'h00, "bsr0F");
    add(1, 2'b11, 8'h01, 8'hA5, 8'h5A, 8'h97, 8'h00, "bsr01");
    add(0, 2'b11, 8'h00, 8'hA5, 8'h5A, 8'h97, 8'h80, "rd_ctrl_after_bsr");
    add(0, 2'b10, 8'h00, 8'hA5, 8'h5A, 8'h97, 8'h97, "rd_pc_after_bsr");

    // Reset held low for 4 cycles.
    repeat (4) step();
    chk_pins("reset", 8'hFF, 8'hFF, 8'hFF);
    chk("reset d idle", d, 8'hFF);
    reset = 1'b1;
    step();
    do_read(2'b11, rv);
    chk("reset ctrl", rv, 8'h9B);

    foreach (vecs[i]) begin
      if (vecs[i].wr_op) begin
        do_write(vecs[i].ad, vecs[i].dat);
      end else begin
        do_read(vecs[i].ad, rv);
        chk({vecs[i].nm, " d"}, rv, vecs[i].e_d);
      end
      chk_pins(vecs[i].nm, vecs[i].e_pa, vecs[i].e_pb, vecs[i].e_pc);
    end

    // Input mode: external pins read back, and a mode set clears the latch.
    do_write(2'b11, 8'h9B);
    ext_pa = 8'h3C; ext_pb = 8'hC3; ext_pc = 8'h5A;
    pa_oe = 1'b1; pb_oe = 1'b1; pch_oe = 1'b1; pcl_oe = 1'b1;
    #1;
    do_read(2'b00, rv); chk("in rd_pa", rv, 8'h3C);
    do_read(2'b01, rv); chk("in rd_pb", rv, 8'hC3);
    do_read(2'b10, rv); chk("in rd_pc", rv, 8'h5A);
    do_write(2'b00, 8'hFF);
    chk("in pa still ext", pa, 8'h3C);
    pa_oe = 1'b0; pb_oe = 1'b0; pch_oe = 1'b0; pcl_oe = 1'b0;
    do_write(2'b11, 8'h80);
    chk_pins("modeset clears", 8'h00, 8'h00, 8'h00);

    // Simultaneous rd+wr commits the write; cs=0 ignores strobes.
    cs = 1'b1; rd = 1'b1; wr = 1'b1; a = 2'b01; d_drv = 8'hC6; d_oe = 1'b1;
    step();
    cs = 1'b0; rd = 1'b0; wr = 1'b0; d_oe = 1'b0;
    chk("rdwr commit pb", pb, 8'hC6);
    cs = 1'b0; wr = 1'b1; a = 2'b01; d_drv = 8'h11; d_oe = 1'b1;
    step();
    wr = 1'b0; d_oe = 1'b0;
    chk("cs0 write ignored", pb, 8'hC6);
    rd = 1'b1; a = 2'b01;
    #2;
    chk("cs0 read d hiz", d, 8'hFF);
    rd = 1'b0;
    #1;
    do_read(2'b01, rv); chk("rd_pb after rdwr", rv, 8'hC6);

    // Reset mid-operation beats a simultaneous write.
    do_write(2'b00, 8'h77);
    chk("pre-reset pa", pa, 8'h77);
    reset = 1'b0; cs = 1'b1; wr = 1'b1; a = 2'b11; d_drv = 8'h80; d_oe = 1'b1;
    step();
    cs = 1'b0; wr = 1'b0; d_oe = 1'b0;
    chk_pins("midreset", 8'hFF, 8'hFF, 8'hFF);
    reset = 1'b1;
    step();
    do_read(2'b11, rv); chk("midreset ctrl", rv, 8'h9B);

    // Randomized phase against the reference model.
    m_ctrl = 8'h9B;
    m_lat[0] = 8'h00; m_lat[1] = 8'h00; m_lat[2] = 8'h00;
    for (int it = 0; it < 300; it++) begin
      pa_oe = 1'b0; pb_oe = 1'b0; pch_oe = 1'b0; pcl_oe = 1'b0;
      op = $urandom_range(0, 9);
      dat = 8'($urandom);
      if (op < 2) begin
        w = {1'b1, dat[6:0]};
        do_write(2'b11, w);
        m_ctrl = w;
        m_lat[0] = 8'h00; m_lat[1] = 8'h00; m_lat[2] = 8'h00;
      end else if (op < 4) begin
        w = {1'b0, dat[6:0]};
        do_write(2'b11, w);
        m_lat[2][w[3:1]] = w[0];
      end else begin
        ad = $urandom_range(0, 2);
        do_write(2'(ad), dat);
        m_lat[ad] = dat;
      end
      ext_pa = 8'($urandom); ext_pb = 8'($urandom); ext_pc = 8'($urandom);
      pa_oe = m_ctrl[4]; pb_oe = m_ctrl[1]; pch_oe = m_ctrl[3]; pcl_oe = m_ctrl[0];
      #1;
      chk("rnd pa", pa, exp_pin(0));
      chk("rnd pb", pb, exp_pin(1));
      chk("rnd pc", pc, exp_pin(2));
      ad = $urandom_range(0, 3);
      do_read(2'(ad), rv);
      chk("rnd read", rv, (ad == 3) ? m_ctrl : exp_pin(ad));
    end
    pa_oe = 1'b0; pb_oe = 1'b0; pch_oe = 1'b0; pcl_oe = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
